alu_control_sequencer: RTL and testbench

- Hardwired control unit sitting directly upstream of DataPath. Drives its bus-select, register-enable, memory and ALU controls.
- Sequences fetch (T0-T2) and execute (T3-T6) for register-register ALU instructions.
- Decodes the IR fields itself, which replaces the hand-coded per-state control of the datapath benches.

---
 rtl/alu_control_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute sequencer for register-register ALU instructions on DataPath.
// Define SEQ_STEP_EN to add a w_step input that gates every non-IDLE state transition.
module alu_control_sequencer #(
    parameter int unsigned OPC_W    = 5,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned LAST_OPC = 12
) (
    input  logic             w_clock,
    input  logic             w_clear,
    input  logic             w_run,
    input  logic             w_mem_ready,
`ifdef SEQ_STEP_EN
    input  logic             w_step,
`endif
    input  logic [31:0]      ir,
    output logic             s_PC,
    output logic             s_Zlow,
    output logic             s_Zhigh,
    output logic             s_MDR,
    output logic             s_Rout,
    output logic [REG_W-1:0] r_out_sel,
    output logic             e_Rin,
    output logic [REG_W-1:0] r_in_sel,
    output logic             e_MAR,
    output logic             e_Z,
    output logic             e_PC,
    output logic             e_MDR,
    output logic             e_IR,
    output logic             e_Y,
    output logic             e_HI,
    output logic             e_LO,
    output logic             w_IncPC,
    output logic             w_read,
    output logic             e_alu,
    output logic [OPC_W-1:0] opcode,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_illegal
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] T0   = 3'd1;
    localparam logic [2:0] T1   = 3'd2;
    localparam logic [2:0] T2   = 3'd3;
    localparam logic [2:0] T3   = 3'd4;
    localparam logic [2:0] T4   = 3'd5;
    localparam logic [2:0] T5   = 3'd6;
    localparam logic [2:0] T6   = 3'd7;

    localparam int unsigned OpcHi = 31;
    localparam int unsigned RaHi  = OpcHi - OPC_W;
    localparam int unsigned RbHi  = RaHi - REG_W;
    localparam int unsigned RcHi  = RbHi - REG_W;
    localparam int unsigned LoTop = RcHi - REG_W;

    localparam logic [OPC_W-1:0] LastOpc = OPC_W'(LAST_OPC);
    localparam logic [OPC_W-1:0] OpcNot  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OpcMul  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OpcDiv  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OpcNeg  = OPC_W'(12);

    logic [2:0]       state_q, state_d;
    logic [OPC_W-1:0] opc_q;
    logic [REG_W-1:0] ra_q, rb_q, rc_q;
    logic             advance;
    logic             unused_ir;

`ifdef SEQ_STEP_EN
    assign advance = w_step;
`else
    assign advance = 1'b1;
`endif

    assign unused_ir = ^ir[LoTop:0];

    // IR is only valid from T3 on, so T3 decodes it live and latches it for T4-T6.
    logic [OPC_W-1:0] cur_opc;
    logic [REG_W-1:0] cur_ra, cur_rb, cur_rc;
    logic             is_illegal, is_unary, is_muldiv;

    always_comb begin
        if (state_q == T3) begin
            cur_opc = ir[OpcHi -: OPC_W];
            cur_ra  = ir[RaHi -: REG_W];
            cur_rb  = ir[RbHi -: REG_W];
            cur_rc  = ir[RcHi -: REG_W];
        end else begin
            cur_opc = opc_q;
            cur_ra  = ra_q;
            cur_rb  = rb_q;
            cur_rc  = rc_q;
        end
        is_illegal = cur_opc > LastOpc;
        is_unary   = (cur_opc == OpcNot) || (cur_opc == OpcNeg);
        is_muldiv  = (cur_opc == OpcMul) || (cur_opc == OpcDiv);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (w_run) state_d = T0;
            T0:   if (advance) state_d = T1;
            T1:   if (advance && w_mem_ready) state_d = T2;
            T2:   if (advance) state_d = T3;
            T3:   if (advance) state_d = is_illegal ? IDLE : T4;
            T4:   if (advance) state_d = T5;
            T5: begin
                if (advance) begin
                    if (is_muldiv) state_d = T6;
                    else           state_d = w_run ? T0 : IDLE;
                end
            end
            T6:   if (advance) state_d = w_run ? T0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clock or negedge w_clear) begin
        if (!w_clear) begin
            state_q <= IDLE;
            opc_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T3 && advance) begin
                opc_q <= cur_opc;
                ra_q  <= cur_ra;
                rb_q  <= cur_rb;
                rc_q  <= cur_rc;
            end
        end
    end

    always_comb begin
        s_PC      = 1'b0;
        s_Zlow    = 1'b0;
        s_Zhigh   = 1'b0;
        s_MDR     = 1'b0;
        s_Rout    = 1'b0;
        r_out_sel = '0;
        e_Rin     = 1'b0;
        r_in_sel  = '0;
        e_MAR     = 1'b0;
        e_Z       = 1'b0;
        e_PC      = 1'b0;
        e_MDR     = 1'b0;
        e_IR      = 1'b0;
        e_Y       = 1'b0;
        e_HI      = 1'b0;
        e_LO      = 1'b0;
        w_IncPC   = 1'b0;
        w_read    = 1'b0;
        e_alu     = 1'b0;
        opcode    = '0;
        o_busy    = (state_q != IDLE);
        o_done    = 1'b0;
        o_illegal = 1'b0;
        case (state_q)
            T0: begin
                s_PC    = 1'b1;
                e_MAR   = 1'b1;
                w_IncPC = 1'b1;
                e_Z     = 1'b1;
            end
            T1: begin
                s_Zlow = 1'b1;
                e_PC   = 1'b1;
                w_read = 1'b1;
                e_MDR  = 1'b1;
            end
            T2: begin
                s_MDR = 1'b1;
                e_IR  = 1'b1;
            end
            T3: begin
                if (is_illegal) begin
                    o_illegal = 1'b1;
                end else if (!is_unary) begin
                    s_Rout    = 1'b1;
                    r_out_sel = cur_rb;
                    e_Y       = 1'b1;
                end
            end
            T4: begin
                s_Rout    = 1'b1;
                r_out_sel = is_unary ? cur_rb : cur_rc;
                e_alu     = 1'b1;
                e_Z       = 1'b1;
                opcode    = cur_opc;
            end
            T5: begin
                s_Zlow = 1'b1;
                if (is_muldiv) begin
                    e_LO = 1'b1;
                end else begin
                    e_Rin    = 1'b1;
                    r_in_sel = cur_ra;
                    o_done   = 1'b1;
                end
            end
            T6: begin
                s_Zhigh = 1'b1;
                e_HI    = 1'b1;
                o_done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Randomized bench: builds a cycle-by-cycle instruction-level expectation and compares each cycle.
module tb_alu_control_sequencer;

    logic        w_clock = 1'b0;
    logic        w_clear, w_run, w_mem_ready;
    logic [31:0] ir;
    logic        s_PC, s_Zlow, s_Zhigh, s_MDR, s_Rout, e_Rin;
    logic [3:0]  r_out_sel, r_in_sel;
    logic        e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, w_IncPC, w_read, e_alu;
    logic [4:0]  opcode;
    logic        o_busy, o_done, o_illegal;

    alu_control_sequencer dut (
        .w_clock(w_clock), .w_clear(w_clear), .w_run(w_run), .w_mem_ready(w_mem_ready),
`ifdef SEQ_STEP_EN
        .w_step(1'b1),
`endif
        .ir(ir), .s_PC(s_PC), .s_Zlow(s_Zlow), .s_Zhigh(s_Zhigh), .s_MDR(s_MDR),
        .s_Rout(s_Rout), .r_out_sel(r_out_sel), .e_Rin(e_Rin), .r_in_sel(r_in_sel),
        .e_MAR(e_MAR), .e_Z(e_Z), .e_PC(e_PC), .e_MDR(e_MDR), .e_IR(e_IR), .e_Y(e_Y),
        .e_HI(e_HI), .e_LO(e_LO), .w_IncPC(w_IncPC), .w_read(w_read), .e_alu(e_alu),
        .opcode(opcode), .o_busy(o_busy), .o_done(o_done), .o_illegal(o_illegal)
    );

    always #5 w_clock = ~w_clock;

    typedef struct packed {
        logic       s_pc, s_zlow, s_zhigh, s_mdr, s_rout;
        logic [3:0] r_out_sel;
        logic       e_rin;
        logic [3:0] r_in_sel;
        logic       e_mar, e_z, e_pc, e_mdr, e_ir, e_y, e_hi, e_lo, inc_pc, read, e_alu;
        logic [4:0] opcode;
        logic       busy, done, illegal;
    } ovec_t;

    typedef struct packed {
        logic [31:0] ir;
        logic        run, ready;
    } stim_t;

    ovec_t exp_q[$];
    stim_t stim_q[$];
    int    t3_idx[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    chk_en  = 0;

    function automatic ovec_t dut_vec();
        ovec_t v;
        v = '{s_PC, s_Zlow, s_Zhigh, s_MDR, s_Rout, r_out_sel, e_Rin, r_in_sel, e_MAR, e_Z,
              e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, w_IncPC, w_read, e_alu, opcode, o_busy,
              o_done, o_illegal};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_cyc(input logic [31:0] i, input logic r, input logic m, input ovec_t v);
        stim_t s;
        s.ir = i; s.run = r; s.ready = m;
        stim_q.push_back(s);
        exp_q.push_back(v);
    endtask

    // Expected per-cycle outputs of one instruction, derived from its class alone.
    task automatic push_instr(input logic [31:0] i, input int stalls, input bit run_after);
        ovec_t v;
        logic [4:0] opc = i[31:27];
        logic [3:0] ra = i[26:23], rb = i[22:19], rc = i[18:15];
        bit unary  = (opc == 5'd4) || (opc == 5'd12);
        bit muldiv = (opc == 5'd5) || (opc == 5'd6);
        v = '0; v.busy = 1; v.s_pc = 1; v.e_mar = 1; v.inc_pc = 1; v.e_z = 1;
        push_cyc($urandom, 1'($urandom), 1'($urandom), v);
        for (int k = 0; k <= stalls; k++) begin
            v = '0; v.busy = 1; v.s_zlow = 1; v.e_pc = 1; v.read = 1; v.e_mdr = 1;
            push_cyc($urandom, 1'($urandom), k == stalls, v);
        end
        v = '0; v.busy = 1; v.s_mdr = 1; v.e_ir = 1;
        push_cyc($urandom, 1'($urandom), 1'($urandom), v);
        t3_idx.push_back(exp_q.size());
        v = '0; v.busy = 1;
        if (opc > 5'd12) v.illegal = 1;
        else if (!unary) begin v.s_rout = 1; v.r_out_sel = rb; v.e_y = 1; end
        push_cyc(i, 1'($urandom), 1'($urandom), v);
        if (opc > 5'd12) return;
        v = '0; v.busy = 1; v.s_rout = 1; v.e_alu = 1; v.e_z = 1; v.opcode = opc;
        v.r_out_sel = unary ? rb : rc;
        push_cyc($urandom, 1'($urandom), 1'($urandom), v);
        v = '0; v.busy = 1; v.s_zlow = 1;
        if (muldiv) begin
            v.e_lo = 1;
            push_cyc($urandom, 1'($urandom), 1'($urandom), v);
            v = '0; v.busy = 1; v.s_zhigh = 1; v.e_hi = 1; v.done = 1;
        end else begin
            v.e_rin = 1; v.r_in_sel = ra; v.done = 1;
        end
        push_cyc($urandom, run_after, 1'($urandom), v);
    endtask

    always @(negedge w_clock) begin
        if (chk_en && cyc < exp_q.size()) begin
            check($sformatf("cycle_%0d_outputs", cyc), 64'(dut_vec()), 64'(exp_q[cyc]));
            n_tests++;
            bus_one_source: assert ($countones({s_PC, s_Zlow, s_Zhigh, s_MDR, s_Rout}) <= 1)
            else begin
                n_fail++;
                $display("FAIL bus_one_source: cycle %0d got %b, expected at most one set",
                         cyc, {s_PC, s_Zlow, s_Zhigh, s_MDR, s_Rout});
            end
        end
    end

    logic [31:0] p_ir[$];
    int          p_st[$];
    int          p_gap[$];

    task automatic add_prog(input logic [31:0] i, input int st, input int gap);
        p_ir.push_back(i); p_st.push_back(st); p_gap.push_back(gap);
    endtask

    initial begin
        ovec_t v;
        logic [31:0] ri;
        bool_done: begin end
        // Directed program followed by random instructions; gap = idle cycles before start.
        add_prog(32'h50918000, 0, 1);
        add_prog(32'h28918000, 0, 0);
        add_prog(32'h62280000, 0, 0);
        add_prog(32'hF8000000, 0, 0);
        add_prog(32'h51A30000, 3, 2);
        for (int j = 0; j < 40; j++) begin
            ri = $urandom;
            ri[31:27] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(13, 31))
                                                    : 5'($urandom_range(0, 12));
            add_prog(ri, $urandom_range(0, 3),
                     (p_ir[p_ir.size()-1][31:27] > 5'd12) ? $urandom_range(1, 2)
                                                          : $urandom_range(0, 2));
        end
        for (int j = 0; j < p_ir.size(); j++) begin
            for (int g = 0; g < p_gap[j]; g++) begin
                v = '0;
                push_cyc($urandom, g == p_gap[j] - 1, 1'($urandom), v);
            end
            push_instr(p_ir[j], p_st[j], (j + 1 < p_ir.size()) && (p_gap[j+1] == 0));
        end
        for (int g = 0; g < 3; g++) begin
            v = '0;
            push_cyc($urandom, 1'b0, 1'($urandom), v);
        end

        // Pin the model itself against hand-derived values.
        check("model_shra_t4_opcode", 64'(exp_q[t3_idx[0]+1].opcode), 64'd10);
        check("model_shra_t4_rsel", 64'(exp_q[t3_idx[0]+1].r_out_sel), 64'd3);
        check("model_shra_t5_rin", 64'({exp_q[t3_idx[0]+2].e_rin, exp_q[t3_idx[0]+2].r_in_sel,
                                        exp_q[t3_idx[0]+2].done}), 64'b1_0001_1);
        check("model_shra_len", 64'(t3_idx[1] - t3_idx[0]), 64'd6);
        check("model_mul_len", 64'(t3_idx[2] - t3_idx[1]), 64'd7);
        check("model_neg_t4", 64'({exp_q[t3_idx[2]+1].r_out_sel, exp_q[t3_idx[2]+1].opcode}),
              64'({4'd5, 5'd12}));
        check("model_neg_no_y", 64'(exp_q[t3_idx[2]].e_y), 64'd0);
        check("model_illegal_t3", 64'(exp_q[t3_idx[3]].illegal), 64'd1);

        w_clear = 1'b0; w_run = 1'b0; w_mem_ready = 1'b0; ir = '0;
        repeat (3) @(posedge w_clock);
        #1;
        check("reset_outputs", 64'(dut_vec()), 64'd0);
        w_clear = 1'b1;
        cyc = 0;
        {ir, w_run, w_mem_ready} = stim_q[0];
        chk_en = 1;
        for (int t = 1; t < stim_q.size(); t++) begin
            @(posedge w_clock);
            #1;
            cyc = t;
            {ir, w_run, w_mem_ready} = stim_q[t];
        end
        @(negedge w_clock);
        #1;
        chk_en = 0;

        // Asynchronous clear in the middle of an instruction.
        ir = 32'h50918000; w_run = 1'b1; w_mem_ready = 1'b1;
        repeat (5) @(posedge w_clock);
        @(negedge w_clock);
        check("t4_before_clear", 64'({o_busy, e_alu, opcode}), 64'({1'b1, 1'b1, 5'd10}));
        #1 w_clear = 1'b0;
        #1 check("async_clear", 64'(dut_vec()), 64'd0);
        @(posedge w_clock);
        #1 check("clear_held", 64'(dut_vec()), 64'd0);
        w_clear = 1'b1;
        @(negedge w_clock);
        check("idle_after_release", 64'(dut_vec()), 64'd0);
        @(posedge w_clock);
        #1 w_run = 1'b0;
        @(negedge w_clock);
        v = '0; v.busy = 1; v.s_pc = 1; v.e_mar = 1; v.inc_pc = 1; v.e_z = 1;
        check("restart_t0", 64'(dut_vec()), 64'(v));
        begin
            int n = 0;
            while (!o_done && n < 20) begin
                @(negedge w_clock);
                n++;
            end
            check("restart_retires_cycles", 64'(n), 64'd5);
        end
        @(negedge w_clock);
        check("idle_after_retire", 64'(o_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
